dedup_sequencer: RTL and testbench

Controller that sequences a remove-duplicates datapath over a sorted array. It accepts up to NUM_ELEMENTS words on a valid/ready stream into a local buffer. It then runs a two-pointer compaction scan, one comparison per cycle, and streams the k unique elements out on a second valid/ready port. It replaces whole-array port passing with a streamed, handshaked job interface for the array-processing blocks.

---
 rtl/dedup_pkg.sv | 20 ++
 rtl/dedup_buffer.sv | 37 +++
 rtl/dedup_sequencer.sv | 142 ++++++++++++++
 tb/tb_dedup_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dedup_pkg.sv
// Shared types and sizing helpers for the remove-duplicates sequencer.
package dedup_pkg;

   localparam int DEF_NUM_ELEMENTS = 10;
   localparam int DEF_DATA_W       = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SCAN,
      ST_DRAIN,
      ST_DONE
   } dedup_state_t;

   // Width that can hold every value 0..n (length, index and count).
   function automatic int calc_idx_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/dedup_buffer.sv
// Element store: one synchronous write port, two combinational read ports.
module dedup_buffer
   import dedup_pkg::*;
#(
   parameter int NUM_ELEMENTS = DEF_NUM_ELEMENTS,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int IDX_W        = calc_idx_w(DEF_NUM_ELEMENTS)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [IDX_W-1:0]  i_raddr_a,
   output logic [DATA_W-1:0] o_rdata_a,
   input  logic [IDX_W-1:0]  i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_b
);

   logic [DATA_W-1:0] r_mem [NUM_ELEMENTS];

   // Address decode by compare keeps index widths independent of the depth.
   always_ff @(posedge clk) begin
      for (int e = 0; e < NUM_ELEMENTS; e++) begin
         if (i_we && (i_waddr == IDX_W'(e))) r_mem[e] <= i_wdata;
      end
   end

   always_comb begin
      o_rdata_a = '0;
      o_rdata_b = '0;
      for (int e = 0; e < NUM_ELEMENTS; e++) begin
         if (i_raddr_a == IDX_W'(e)) o_rdata_a = r_mem[e];
         if (i_raddr_b == IDX_W'(e)) o_rdata_b = r_mem[e];
      end
   end

endmodule

// File: rtl/dedup_sequencer.sv
// Streams in a sorted array, compacts duplicates in place with a two-pointer
// scan (one compare per cycle), then streams the unique elements out.
module dedup_sequencer
   import dedup_pkg::*;
#(
   parameter  int NUM_ELEMENTS = DEF_NUM_ELEMENTS,
   parameter  int DATA_W       = DEF_DATA_W,
   localparam int IDX_W        = calc_idx_w(NUM_ELEMENTS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IDX_W-1:0]  len,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [31:0]       k,
   output logic              busy,
   output logic              done,
   output logic              sort_err
);

   localparam logic [IDX_W-1:0] NE  = IDX_W'(NUM_ELEMENTS);
   localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

   dedup_state_t r_state, w_next;

   logic [IDX_W-1:0]  r_len, r_wr_idx, r_i, r_kcnt, r_rd_idx, r_k;
   logic              r_sort_err;

   logic [IDX_W-1:0]  w_len_q;
   logic              w_in_fire, w_out_fire, w_last_in, w_last_scan, w_last_out;
   logic              w_scan, w_distinct, w_desc;
   logic              w_we;
   logic [IDX_W-1:0]  w_waddr, w_raddr_cmp;
   logic [DATA_W-1:0] w_wdata, w_rd_scan, w_rd_cmp;

   assign w_len_q     = (len > NE) ? NE : len;
   assign w_scan      = (r_state == ST_SCAN);
   assign w_in_fire   = in_valid && (r_state == ST_LOAD);
   assign w_out_fire  = out_ready && (r_state == ST_DRAIN);
   assign w_last_in   = w_in_fire && (r_wr_idx == r_len - ONE);
   assign w_last_scan = w_scan && (r_i == r_len - ONE);
   assign w_last_out  = w_out_fire && (r_rd_idx == r_k - ONE);
   assign w_distinct  = (w_rd_scan != w_rd_cmp);
   assign w_desc      = (w_rd_scan < w_rd_cmp);

   // Port B doubles as the compare read (kcnt-1) in SCAN and the drain read.
   assign w_we        = w_in_fire || (w_scan && w_distinct);
   assign w_waddr     = w_scan ? r_kcnt : r_wr_idx;
   assign w_wdata     = w_scan ? w_rd_scan : in_data;
   assign w_raddr_cmp = w_scan ? (r_kcnt - ONE) : r_rd_idx;

   dedup_buffer #(
      .NUM_ELEMENTS (NUM_ELEMENTS),
      .DATA_W       (DATA_W),
      .IDX_W        (IDX_W)
   ) u_buf (
      .clk       (clk),
      .i_we      (w_we),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_raddr_a (r_i),
      .o_rdata_a (w_rd_scan),
      .i_raddr_b (w_raddr_cmp),
      .o_rdata_b (w_rd_cmp)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_next = (w_len_q == '0) ? ST_DONE : ST_LOAD;
         ST_LOAD:  if (w_last_in) w_next = (r_len == ONE) ? ST_DRAIN : ST_SCAN;
         ST_SCAN:  if (w_last_scan) w_next = ST_DRAIN;
         ST_DRAIN: if (w_last_out) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_len      <= '0;
         r_wr_idx   <= '0;
         r_i        <= '0;
         r_kcnt     <= '0;
         r_rd_idx   <= '0;
         r_k        <= '0;
         r_sort_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_len      <= w_len_q;
                  r_wr_idx   <= '0;
                  r_k        <= '0;
                  r_sort_err <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (w_in_fire) r_wr_idx <= r_wr_idx + ONE;
               if (w_last_in) begin
                  r_i      <= ONE;
                  r_kcnt   <= ONE;
                  r_rd_idx <= '0;
                  if (r_len == ONE) r_k <= ONE;
               end
            end
            ST_SCAN: begin
               r_i <= r_i + ONE;
               if (w_distinct) r_kcnt <= r_kcnt + ONE;
               if (w_desc) r_sort_err <= 1'b1;
               if (w_last_scan) begin
                  r_rd_idx <= '0;
                  r_k      <= w_distinct ? (r_kcnt + ONE) : r_kcnt;
               end
            end
            ST_DRAIN: begin
               if (w_out_fire) r_rd_idx <= r_rd_idx + ONE;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_LOAD);
   assign out_valid = (r_state == ST_DRAIN);
   assign out_data  = out_valid ? w_rd_cmp : '0;
   assign k         = 32'(r_k);
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_DONE);
   assign sort_err  = r_sort_err;

endmodule

// File: tb/tb_dedup_sequencer.sv
// Table-driven jobs with an output scoreboard, plus a mid-scan reset sequence.
module tb_dedup_sequencer;

   localparam int NE     = 10;
   localparam int DATA_W = 32;
   localparam int IDX_W  = $clog2(NE + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [IDX_W-1:0]  len = '0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready = 1'b0;
   logic [31:0]       k;
   logic              busy, done, sort_err;

   dedup_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .k         (k),
      .busy      (busy),
      .done      (done),
      .sort_err  (sort_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]        len;
      logic [15:0][31:0] d;
      logic [4:0]        exp_k;
      logic              exp_err;
      logic              stall;
   } vec_t;

   vec_t tbl [10];
   int   dup6 [10] = '{0, 0, 1, 1, 1, 2, 2, 3, 3, 4};
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input int l, input int kk, input bit e, input bit s);
      vec_t r;
      r = '0;
      r.len = 5'(l); r.exp_k = 5'(kk); r.exp_err = e; r.stall = s;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_job(input int vi);
      vec_t        v;
      logic [31:0] exp_q [$];
      logic [31:0] last, held, e;
      bit          have_last, stalled_prev;
      int          lq, sent, got, cyc, done_cyc, lat;
      v = tbl[vi];
      lq = (int'(v.len) > NE) ? NE : int'(v.len);
      have_last = 0; stalled_prev = 0; sent = 0; got = 0; done_cyc = -1;
      last = '0; held = '0;
      @(negedge clk);
      start = 1'b1; len = IDX_W'(v.len); in_valid = 1'b0; out_ready = 1'b0;
      cyc = 1;
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (done) begin
            done_cyc = cyc; in_valid = 1'b0; out_ready = 1'b0;
            break;
         end
         in_valid = 1'b0;
         if (in_ready && !(v.stall && (cyc % 3 == 0)) && sent < 16) begin
            in_valid = 1'b1;
            in_data  = v.d[sent];
            if (!have_last || v.d[sent] != last) exp_q.push_back(v.d[sent]);
            last = v.d[sent]; have_last = 1;
            sent++;
         end
         if (out_valid) begin
            if (stalled_prev) chk($sformatf("v%0d out_stable", vi), out_data, held);
            out_ready = v.stall ? (cyc % 2 == 1) : 1'b1;
            if (out_ready) begin
               if (exp_q.size() == 0) chk($sformatf("v%0d out_extra", vi), out_data, 32'hDEAD_BEEF);
               else begin
                  e = exp_q.pop_front();
                  chk($sformatf("v%0d out_data[%0d]", vi, got), out_data, e);
               end
               got++;
               stalled_prev = 0;
            end else begin
               stalled_prev = 1; held = out_data;
            end
         end else begin
            out_ready = 1'b0; stalled_prev = 0;
         end
      end
      if (done_cyc < 0) chk($sformatf("v%0d done_timeout", vi), 32'd0, 32'd1);
      chk($sformatf("v%0d accepted", vi), 32'(sent), 32'(lq));
      chk($sformatf("v%0d out_count", vi), 32'(got), 32'(v.exp_k));
      chk($sformatf("v%0d sb_left", vi), 32'(exp_q.size()), 32'd0);
      chk($sformatf("v%0d k", vi), k, 32'(v.exp_k));
      chk($sformatf("v%0d sort_err", vi), 32'(sort_err), 32'(v.exp_err));
      if (!v.stall) begin
         lat = (lq == 0) ? 2 : (1 + lq + (lq - 1) + int'(v.exp_k) + 1);
         chk($sformatf("v%0d latency", vi), 32'(done_cyc), 32'(lat));
      end
      @(negedge clk);
      chk($sformatf("v%0d done_pulse", vi), {30'd0, done, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = mk(10, 10, 0, 0); for (int j = 0; j < 16; j++) tbl[0].d[j] = 32'(j);
      tbl[1] = mk(3, 2, 0, 0);   tbl[1].d[0] = 1; tbl[1].d[1] = 1; tbl[1].d[2] = 2;
      tbl[2] = mk(10, 1, 0, 0);  for (int j = 0; j < 16; j++) tbl[2].d[j] = 32'd7;
      tbl[3] = mk(1, 1, 0, 0);   tbl[3].d[0] = 5;
      tbl[4] = mk(0, 0, 0, 0);
      tbl[5] = mk(15, 10, 0, 0); for (int j = 0; j < 16; j++) tbl[5].d[j] = 32'(j);
      tbl[6] = mk(10, 5, 0, 1);  for (int j = 0; j < 10; j++) tbl[6].d[j] = 32'(dup6[j]);
      tbl[7] = mk(2, 2, 1, 0);   tbl[7].d[0] = 3; tbl[7].d[1] = 1;
      tbl[8] = mk(2, 1, 0, 0);   tbl[8].d[0] = 4; tbl[8].d[1] = 4;
      tbl[9] = mk(2, 1, 0, 0);   tbl[9].d[0] = 2; tbl[9].d[1] = 2;

      repeat (2) @(negedge clk);
      chk("reset outputs", {27'd0, in_ready, out_valid, busy, done, sort_err}, 32'd0);
      chk("reset k", k, 32'd0);
      chk("reset out_data", out_data, 32'd0);
      rst = 1'b1;

      for (int vi = 0; vi < 9; vi++) run_job(vi);

      // Abort mid-scan: [3,1,2,2] sets sort_err on the first compare.
      @(negedge clk);
      start = 1'b1; len = IDX_W'(4);
      @(negedge clk);
      start = 1'b0;
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("rst_seq in_ready[%0d]", j), 32'(in_ready), 32'd1);
         in_valid = 1'b1;
         in_data  = (j == 0) ? 32'd3 : (j == 1) ? 32'd1 : 32'd2;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("rst_seq scan busy", {30'd0, busy, in_ready}, 32'd2);
      @(negedge clk);
      chk("rst_seq err before rst", 32'(sort_err), 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_seq outputs", {27'd0, in_ready, out_valid, busy, done, sort_err}, 32'd0);
      chk("rst_seq k", k, 32'd0);
      chk("rst_seq out_data", out_data, 32'd0);
      @(negedge clk);
      chk("rst_seq no done", 32'(done), 32'd0);
      rst = 1'b1;
      run_job(9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
